// File: rtl/dual_core_mem_arbiter.sv
// Round-robin arbiter that lets two mips cores share one memory bus.
// A granted request is latched, strobed for ACCESS_CYCLES cycles, then acknowledged with a one-cycle ready pulse.
module dual_core_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ACCESS_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  c0_memread,
  input  logic                  c0_memwrite,
  input  logic [ADDR_WIDTH-1:0] c0_addr,
  input  logic [DATA_WIDTH-1:0] c0_writedata,
  output logic [DATA_WIDTH-1:0] c0_memdata,
  output logic                  c0_ready,
  input  logic                  c1_memread,
  input  logic                  c1_memwrite,
  input  logic [ADDR_WIDTH-1:0] c1_addr,
  input  logic [DATA_WIDTH-1:0] c1_writedata,
  output logic [DATA_WIDTH-1:0] c1_memdata,
  output logic                  c1_ready,
  output logic                  bus_memread,
  output logic                  bus_memwrite,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_writedata,
  input  logic [DATA_WIDTH-1:0] bus_memdata,
  output logic                  bus_owner
);

  localparam int unsigned CntWidth = 4;
  localparam logic [CntWidth-1:0] CntLoad = CntWidth'(ACCESS_CYCLES - 1);

  if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 15) begin : g_bad_access_cycles
    $error("ACCESS_CYCLES must be in 1..15");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e                state_q;
  logic [CntWidth-1:0]   cnt_q;
  logic                  last_grant_q;

  logic                  c0_req;
  logic                  c1_req;
  logic                  grant_valid;
  logic                  grant_core;
  logic                  sel_read;
  logic                  sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  assign c0_req = c0_memread | c0_memwrite;
  assign c1_req = c1_memread | c1_memwrite;

  // On a tie the core that did not win last time goes next.
  always_comb begin
    grant_valid = c0_req | c1_req;
    grant_core  = 1'b0;
    if (c0_req && c1_req) begin
      grant_core = ~last_grant_q;
    end else if (c1_req) begin
      grant_core = 1'b1;
    end
  end

  // Write takes precedence when a core raises both strobes.
  always_comb begin
    sel_write = grant_core ? c1_memwrite : c0_memwrite;
    sel_read  = (grant_core ? c1_memread : c0_memread) & ~sel_write;
    sel_addr  = grant_core ? c1_addr : c0_addr;
    sel_wdata = grant_core ? c1_writedata : c0_writedata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      last_grant_q  <= 1'b1;
      bus_owner     <= 1'b0;
      bus_memread   <= 1'b0;
      bus_memwrite  <= 1'b0;
      bus_addr      <= '0;
      bus_writedata <= '0;
      c0_memdata    <= '0;
      c1_memdata    <= '0;
      c0_ready      <= 1'b0;
      c1_ready      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_valid) begin
            bus_memread   <= sel_read;
            bus_memwrite  <= sel_write;
            bus_addr      <= sel_addr;
            bus_writedata <= sel_wdata;
            bus_owner     <= grant_core;
            last_grant_q  <= grant_core;
            cnt_q         <= CntLoad;
            state_q       <= StBusy;
          end
        end
        StBusy: begin
          if (cnt_q == '0) begin
            if (bus_memread) begin
              if (bus_owner) begin
                c1_memdata <= bus_memdata;
              end else begin
                c0_memdata <= bus_memdata;
              end
            end
            bus_memread  <= 1'b0;
            bus_memwrite <= 1'b0;
            c0_ready     <= ~bus_owner;
            c1_ready     <= bus_owner;
            state_q      <= StDone;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StDone: begin
          c0_ready <= 1'b0;
          c1_ready <= 1'b0;
          state_q  <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dual_core_mem_arbiter.sv
// Directed bench for dual_core_mem_arbiter: one instance with ACCESS_CYCLES=1, one with 3.
// Both instances share the core and bus-data inputs.
module tb_dual_core_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        c0_memread;
  logic        c0_memwrite;
  logic [15:0] c0_addr;
  logic [7:0]  c0_writedata;
  logic        c1_memread;
  logic        c1_memwrite;
  logic [15:0] c1_addr;
  logic [7:0]  c1_writedata;
  logic [7:0]  bus_memdata;

  logic [7:0]  a_c0_memdata, a_c1_memdata, a_bus_writedata;
  logic        a_c0_ready, a_c1_ready, a_bus_memread, a_bus_memwrite, a_bus_owner;
  logic [15:0] a_bus_addr;
  logic [7:0]  b_c0_memdata, b_c1_memdata, b_bus_writedata;
  logic        b_c0_ready, b_c1_ready, b_bus_memread, b_bus_memwrite, b_bus_owner;
  logic [15:0] b_bus_addr;

  int n_total = 0;
  int n_bad   = 0;

  dual_core_mem_arbiter #(
    .ADDR_WIDTH   (16),
    .DATA_WIDTH   (8),
    .ACCESS_CYCLES(1)
  ) u_dut1 (
    .clk          (clk),
    .reset        (reset),
    .c0_memread   (c0_memread),
    .c0_memwrite  (c0_memwrite),
    .c0_addr      (c0_addr),
    .c0_writedata (c0_writedata),
    .c0_memdata   (a_c0_memdata),
    .c0_ready     (a_c0_ready),
    .c1_memread   (c1_memread),
    .c1_memwrite  (c1_memwrite),
    .c1_addr      (c1_addr),
    .c1_writedata (c1_writedata),
    .c1_memdata   (a_c1_memdata),
    .c1_ready     (a_c1_ready),
    .bus_memread  (a_bus_memread),
    .bus_memwrite (a_bus_memwrite),
    .bus_addr     (a_bus_addr),
    .bus_writedata(a_bus_writedata),
    .bus_memdata  (bus_memdata),
    .bus_owner    (a_bus_owner)
  );

  dual_core_mem_arbiter #(
    .ADDR_WIDTH   (16),
    .DATA_WIDTH   (8),
    .ACCESS_CYCLES(3)
  ) u_dut3 (
    .clk          (clk),
    .reset        (reset),
    .c0_memread   (c0_memread),
    .c0_memwrite  (c0_memwrite),
    .c0_addr      (c0_addr),
    .c0_writedata (c0_writedata),
    .c0_memdata   (b_c0_memdata),
    .c0_ready     (b_c0_ready),
    .c1_memread   (c1_memread),
    .c1_memwrite  (c1_memwrite),
    .c1_addr      (c1_addr),
    .c1_writedata (c1_writedata),
    .c1_memdata   (b_c1_memdata),
    .c1_ready     (b_c1_ready),
    .bus_memread  (b_bus_memread),
    .bus_memwrite (b_bus_memwrite),
    .bus_addr     (b_bus_addr),
    .bus_writedata(b_bus_writedata),
    .bus_memdata  (bus_memdata),
    .bus_owner    (b_bus_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    c0_memread   = 1'b0;
    c0_memwrite  = 1'b0;
    c0_addr      = '0;
    c0_writedata = '0;
    c1_memread   = 1'b0;
    c1_memwrite  = 1'b0;
    c1_addr      = '0;
    c1_writedata = '0;
    bus_memdata  = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    #2;
    do_reset();

    // Reset values
    check("rst_rd",    32'(a_bus_memread), 32'h0);
    check("rst_wr",    32'(a_bus_memwrite), 32'h0);
    check("rst_addr",  32'(a_bus_addr), 32'h0);
    check("rst_wdata", 32'(a_bus_writedata), 32'h0);
    check("rst_owner", 32'(a_bus_owner), 32'h0);
    check("rst_c0rdy", 32'(a_c0_ready), 32'h0);
    check("rst_c1rdy", 32'(a_c1_ready), 32'h0);
    check("rst_c0md",  32'(a_c0_memdata), 32'h0);
    check("rst_c1md",  32'(a_c1_memdata), 32'h0);

    // Single c0 read, ACCESS_CYCLES=1
    c0_memread  = 1'b1;
    c0_addr     = 16'h0010;
    bus_memdata = 8'hA5;
    tick();
    check("t1_rd_hi",   32'(a_bus_memread), 32'h1);
    check("t1_addr",    32'(a_bus_addr), 32'h0010);
    check("t1_owner",   32'(a_bus_owner), 32'h0);
    check("t1_rdy_lo",  32'(a_c0_ready), 32'h0);
    tick();
    check("t1_rd_lo",   32'(a_bus_memread), 32'h0);
    check("t1_rdy",     32'(a_c0_ready), 32'h1);
    check("t1_c0md",    32'(a_c0_memdata), 32'hA5);
    check("t1_c1md",    32'(a_c1_memdata), 32'h0);
    check("t1_c1rdy",   32'(a_c1_ready), 32'h0);
    c0_memread = 1'b0;
    tick();
    check("t1_rdy_end", 32'(a_c0_ready), 32'h0);
    check("t1_c0md_hold", 32'(a_c0_memdata), 32'hA5);

    // Simultaneous: c0 write, c1 read
    do_reset();
    c0_memwrite  = 1'b1;
    c0_addr      = 16'h0020;
    c0_writedata = 8'h3C;
    c1_memread   = 1'b1;
    c1_addr      = 16'h0200;
    bus_memdata  = 8'h5A;
    tick();
    check("t2_wr",      32'(a_bus_memwrite), 32'h1);
    check("t2_rd",      32'(a_bus_memread), 32'h0);
    check("t2_wdata",   32'(a_bus_writedata), 32'h3C);
    check("t2_addr0",   32'(a_bus_addr), 32'h0020);
    check("t2_owner0",  32'(a_bus_owner), 32'h0);
    tick();
    check("t2_c0rdy",   32'(a_c0_ready), 32'h1);
    check("t2_wr_lo",   32'(a_bus_memwrite), 32'h0);
    check("t2_c0md",    32'(a_c0_memdata), 32'h0);
    c0_memwrite = 1'b0;
    tick();
    check("t2_idle_addr",  32'(a_bus_addr), 32'h0020);
    check("t2_idle_owner", 32'(a_bus_owner), 32'h0);
    check("t2_c0rdy_lo",   32'(a_c0_ready), 32'h0);
    tick();
    check("t2_rd1",     32'(a_bus_memread), 32'h1);
    check("t2_addr1",   32'(a_bus_addr), 32'h0200);
    check("t2_owner1",  32'(a_bus_owner), 32'h1);
    tick();
    check("t2_c1rdy",   32'(a_c1_ready), 32'h1);
    check("t2_c1md",    32'(a_c1_memdata), 32'h5A);
    c1_memread = 1'b0;

    // Continuous contention: grants must alternate 0,1,0,1,0,1
    do_reset();
    c0_memread = 1'b1;
    c0_addr    = 16'h0001;
    c1_memread = 1'b1;
    c1_addr    = 16'h0002;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("t3_owner%0d", i), 32'(a_bus_owner), 32'(i % 2));
      check($sformatf("t3_rd%0d", i), 32'(a_bus_memread), 32'h1);
      tick();
      check($sformatf("t3_c0rdy%0d", i), 32'(a_c0_ready), 32'((i % 2) == 0));
      check($sformatf("t3_c1rdy%0d", i), 32'(a_c1_ready), 32'((i % 2) == 1));
      tick();
    end
    c0_memread = 1'b0;
    c1_memread = 1'b0;

    // ACCESS_CYCLES=3 c1 read; data captured on the last strobe edge
    do_reset();
    c1_memread = 1'b1;
    c1_addr    = 16'h0300;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("t4_rd%0d", k), 32'(b_bus_memread), 32'h1);
      check($sformatf("t4_rdy%0d", k), 32'(b_c1_ready), 32'h0);
      bus_memdata = 8'((k << 4) | k);
    end
    tick();
    check("t4_rd_lo",  32'(b_bus_memread), 32'h0);
    check("t4_rdy",    32'(b_c1_ready), 32'h1);
    check("t4_c1md",   32'(b_c1_memdata), 32'h33);
    check("t4_c0md",   32'(b_c0_memdata), 32'h0);
    c1_memread  = 1'b0;
    bus_memdata = 8'h44;
    tick();
    check("t4_rdy_lo", 32'(b_c1_ready), 32'h0);
    check("t4_c1md_hold", 32'(b_c1_memdata), 32'h33);

    // Address change mid-transaction must not reach the bus
    do_reset();
    c0_memread = 1'b1;
    c0_addr    = 16'h0010;
    tick();
    check("t5_addr_a", 32'(b_bus_addr), 32'h0010);
    c0_addr = 16'h0099;
    tick();
    check("t5_addr_b", 32'(b_bus_addr), 32'h0010);
    tick();
    check("t5_addr_c", 32'(b_bus_addr), 32'h0010);
    check("t5_rd",     32'(b_bus_memread), 32'h1);
    tick();
    check("t5_rdy",    32'(b_c0_ready), 32'h1);
    check("t5_addr_d", 32'(b_bus_addr), 32'h0010);
    c0_memread = 1'b0;
    tick();

    // Reset asserted mid-BUSY
    do_reset();
    c1_memread = 1'b1;
    c1_addr    = 16'h0250;
    tick();
    check("t6_rd_pre",    32'(b_bus_memread), 32'h1);
    check("t6_owner_pre", 32'(b_bus_owner), 32'h1);
    #3;
    reset = 1'b1;
    #1;
    check("t6_rd_drop",   32'(b_bus_memread), 32'h0);
    check("t6_owner_rst", 32'(b_bus_owner), 32'h0);
    check("t6_addr_rst",  32'(b_bus_addr), 32'h0);
    c1_memread = 1'b0;
    tick();
    check("t6_c1rdy_a",   32'(b_c1_ready), 32'h0);
    tick();
    check("t6_c1rdy_b",   32'(b_c1_ready), 32'h0);
    reset = 1'b0;
    tick();
    check("t6_c1rdy_c",   32'(b_c1_ready), 32'h0);
    check("t6_rd_idle",   32'(b_bus_memread), 32'h0);
    c0_memread = 1'b1;
    c0_addr    = 16'h0011;
    c1_memread = 1'b1;
    c1_addr    = 16'h0022;
    tick();
    check("t6_tie_owner", 32'(b_bus_owner), 32'h0);
    check("t6_tie_addr",  32'(b_bus_addr), 32'h0011);
    check("t6_tie_rd",    32'(b_bus_memread), 32'h1);
    check("t6_tie_owner1", 32'(a_bus_owner), 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
